// File: rtl/iddrx2_align_pkg.sv
// Shared types and constants for the x2-gearing word-alignment controller.
package iddrx2_align_pkg;

    localparam int ALIGN_SEL_W = 3;
    localparam int CNT_W       = 8;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/iddrx2_word_rotator.sv
// Registers the gearbox word and its predecessor, then extracts a 4-bit window
// starting 'off' bits into the two-word history; bit 0 of the result is the earliest bit.
module iddrx2_word_rotator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] word,
    input  logic [1:0] off,
    output logic [3:0] dout
);

    logic [3:0] wcur_reg;
    logic [3:0] wprev_reg;
    logic [3:0] dout_reg;
    logic [7:0] pair;
    logic [3:0] rot_word;

    assign pair = {wcur_reg, wprev_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign rot_word[gi] = pair[3'(gi) + {1'b0, off}];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcur_reg  <= '0;
            wprev_reg <= '0;
            dout_reg  <= '0;
        end else begin
            wcur_reg  <= word;
            wprev_reg <= wcur_reg;
            dout_reg  <= rot_word;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/iddrx2_align_ctrl.sv
// Training FSM for one x2 DDR input slice: sweeps {POL, OFF} until the rotated
// word equals PATTERN, then holds the alignment and optionally re-trains on loss.
module iddrx2_align_ctrl
    import iddrx2_align_pkg::*;
#(
    parameter logic [3:0] PATTERN    = DEFAULT_PATTERN,
    parameter int         MATCH_CNT  = 16,
    parameter int         SETTLE_CYC = 8,
    parameter int         ERR_LIMIT  = 4
) (
    input  logic       SCLK,
    input  logic       RSTN,
    input  logic       START,
    input  logic       TRACK_EN,
    input  logic       QA0,
    input  logic       QB0,
    input  logic       QA1,
    input  logic       QB1,
    output logic       POL,
    output logic [2:0] ALIGN_SEL,
    output logic [3:0] DOUT,
    output logic       DVALID,
    output logic       BUSY,
    output logic       LOCK,
    output logic       FAIL
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_CNT);
    localparam logic [CNT_W-1:0] ERR_LAST    = CNT_W'(ERR_LIMIT);

    state_t                 state_reg, state_next;
    logic [ALIGN_SEL_W-1:0] align_sel_reg, align_sel_next;
    logic [CNT_W-1:0]       settle_cnt_reg, settle_cnt_next;
    logic [CNT_W-1:0]       match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0]       err_cnt_reg, err_cnt_next;
    logic [CNT_W-1:0]       match_inc, err_inc;
    logic [3:0]             dout_w;
    logic                   word_ok;

    iddrx2_word_rotator u_rotator (
        .clk   (SCLK),
        .rst_n (RSTN),
        .word  ({QB1, QA1, QB0, QA0}),
        .off   (align_sel_reg[1:0]),
        .dout  (dout_w)
    );

    assign word_ok   = (dout_w == PATTERN);
    assign match_inc = sat_inc(match_cnt_reg);
    assign err_inc   = sat_inc(err_cnt_reg);

    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg      <= ST_IDLE;
            align_sel_reg  <= '0;
            settle_cnt_reg <= '0;
            match_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            align_sel_reg  <= align_sel_next;
            settle_cnt_reg <= settle_cnt_next;
            match_cnt_reg  <= match_cnt_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        align_sel_next  = align_sel_reg;
        settle_cnt_next = settle_cnt_reg;
        match_cnt_next  = match_cnt_reg;
        err_cnt_next    = err_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_FAIL: begin
                if (START) begin
                    state_next      = ST_SETTLE;
                    align_sel_next  = '0;
                    settle_cnt_next = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg >= SETTLE_LAST) begin
                    state_next     = ST_CHECK;
                    match_cnt_next = '0;
                end else begin
                    settle_cnt_next = sat_inc(settle_cnt_reg);
                end
            end
            ST_CHECK: begin
                // A match reaching the threshold wins over any other event.
                if (word_ok) begin
                    match_cnt_next = match_inc;
                    if (match_inc >= MATCH_LAST) begin
                        state_next   = ST_LOCKED;
                        err_cnt_next = '0;
                    end
                end else if (align_sel_reg == '1) begin
                    state_next = ST_FAIL;
                end else begin
                    state_next      = ST_SETTLE;
                    align_sel_next  = align_sel_reg + 1'b1;
                    settle_cnt_next = '0;
                end
            end
            ST_LOCKED: begin
                err_cnt_next = '0;
                if (TRACK_EN && !word_ok) begin
                    err_cnt_next = err_inc;
                end
                // Loss of lock and START both restart the sweep from candidate 0.
                if ((TRACK_EN && !word_ok && err_inc >= ERR_LAST) || START) begin
                    state_next      = ST_SETTLE;
                    align_sel_next  = '0;
                    settle_cnt_next = '0;
                    err_cnt_next    = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ALIGN_SEL = align_sel_reg;
    assign POL       = align_sel_reg[2];
    assign DOUT      = dout_w;
    assign BUSY      = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    assign LOCK      = (state_reg == ST_LOCKED);
    assign DVALID    = (state_reg == ST_LOCKED);
    assign FAIL      = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_iddrx2_align_ctrl.sv
// Directed bench for iddrx2_align_ctrl: a small gearbox model feeds a rotated
// training stream whose correct capture polarity and offset are chosen per vector.
module tb_iddrx2_align_ctrl;

    localparam logic [3:0] PAT = 4'b0011;

    logic       SCLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       START = 1'b0;
    logic       TRACK_EN = 1'b0;
    logic       QA0, QB0, QA1, QB1;
    logic       POL;
    logic [2:0] ALIGN_SEL;
    logic [3:0] DOUT;
    logic       DVALID, BUSY, LOCK, FAIL;

    int checks = 0;
    int errors = 0;

    // Gearbox model controls
    logic       use_const = 1'b0;
    logic [3:0] const_word = 4'h0;
    logic       good_pol = 1'b0;
    int         sh = 0;
    logic       inject = 1'b0;
    logic [3:0] pin_word;

    iddrx2_align_ctrl dut (
        .SCLK      (SCLK),
        .RSTN      (RSTN),
        .START     (START),
        .TRACK_EN  (TRACK_EN),
        .QA0       (QA0),
        .QB0       (QB0),
        .QA1       (QA1),
        .QB1       (QB1),
        .POL       (POL),
        .ALIGN_SEL (ALIGN_SEL),
        .DOUT      (DOUT),
        .DVALID    (DVALID),
        .BUSY      (BUSY),
        .LOCK      (LOCK),
        .FAIL      (FAIL)
    );

    always #5 SCLK = ~SCLK;

    // Serial stream s[n] = PAT[(n+s) % 4], cut into 4-bit words.
    function automatic logic [3:0] rot_pat(input int s);
        logic [3:0] p;
        logic [3:0] r;
        p = PAT;
        for (int i = 0; i < 4; i++) r[i] = p[(i + s) % 4];
        return r;
    endfunction

    // Wrong polarity yields an aliased 0101 stream that no rotation can match.
    always_comb begin
        pin_word = 4'b0101;
        if (inject)              pin_word = 4'b0000;
        else if (use_const)      pin_word = const_word;
        else if (POL == good_pol) pin_word = rot_pat(sh);
    end
    assign {QB1, QA1, QB0, QA0} = pin_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Pulse START and count edges until BUSY falls (first edge is the one sampling START).
    task automatic run_train(output int cyc, output logic timed_out);
        @(negedge SCLK);
        START = 1'b1;
        cyc = 0;
        timed_out = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge SCLK);
            #1;
            START = 1'b0;
            cyc++;
            if (!BUSY) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output logic timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge SCLK);
            #1;
            if (!BUSY) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    typedef struct {
        string      name;
        logic       use_c;
        logic [3:0] cw;
        logic       gpol;
        int         shift;
        logic       exp_lock;
        logic       exp_fail;
        logic [2:0] exp_sel;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   cyc;
        logic to;
        int   drops;
        logic found;

        // candidate k is entered 9k edges after START; lock needs 8+16+1 more edges
        vecs[0] = '{"aligned",     1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 3'd0, 25};
        vecs[1] = '{"pol0_off3",   1'b0, 4'h0, 1'b0, 1, 1'b1, 1'b0, 3'd3, 52};
        vecs[2] = '{"pol1_off0",   1'b0, 4'h0, 1'b1, 0, 1'b1, 1'b0, 3'd4, 61};
        vecs[3] = '{"pol1_off1",   1'b0, 4'h0, 1'b1, 3, 1'b1, 1'b0, 3'd5, 70};
        vecs[4] = '{"pol1_off2",   1'b0, 4'h0, 1'b1, 2, 1'b1, 1'b0, 3'd6, 79};
        vecs[5] = '{"pol1_off3",   1'b0, 4'h0, 1'b1, 1, 1'b1, 1'b0, 3'd7, 88};
        vecs[6] = '{"const_zero",  1'b1, 4'h0, 1'b0, 0, 1'b0, 1'b1, 3'd7, 73};
        vecs[7] = '{"const_ones",  1'b1, 4'hf, 1'b0, 0, 1'b0, 1'b1, 3'd7, 73};

        // Reset state
        repeat (3) @(posedge SCLK);
        #1;
        check("rst_outputs", {POL, ALIGN_SEL, DOUT, DVALID, BUSY, LOCK, FAIL}, 32'h0);
        @(negedge SCLK);
        RSTN = 1'b1;

        // Training sweep table
        for (int v = 0; v < 8; v++) begin
            @(negedge SCLK);
            use_const  = vecs[v].use_c;
            const_word = vecs[v].cw;
            good_pol   = vecs[v].gpol;
            sh         = vecs[v].shift;
            run_train(cyc, to);
            $display("vector %s: cycles=%0d sel=%0d lock=%0b", vecs[v].name, cyc, ALIGN_SEL, LOCK);
            check({vecs[v].name, "_timeout"}, to, 1'b0);
            check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cyc);
            check({vecs[v].name, "_lock"}, LOCK, vecs[v].exp_lock);
            check({vecs[v].name, "_dvalid"}, DVALID, vecs[v].exp_lock);
            check({vecs[v].name, "_fail_flag"}, FAIL, vecs[v].exp_fail);
            check({vecs[v].name, "_sel"}, ALIGN_SEL, vecs[v].exp_sel);
            check({vecs[v].name, "_pol"}, POL, vecs[v].exp_sel[2]);
            if (vecs[v].exp_lock) check({vecs[v].name, "_dout"}, DOUT, PAT);
        end

        // START while busy is ignored; START in LOCKED restarts
        @(negedge SCLK);
        use_const = 1'b0;
        good_pol  = 1'b1;
        sh        = 2;
        START     = 1'b1;
        cyc = 0;
        to  = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge SCLK);
            #1;
            START = 1'b0;
            cyc++;
            if (cyc == 20) START = 1'b1;
            if (cyc == 21) check("busy_start_sel", ALIGN_SEL, 3'd2);
            if (!BUSY) begin
                to = 1'b0;
                break;
            end
        end
        check("busy_start_timeout", to, 1'b0);
        check("busy_start_cycles", cyc, 79);
        check("busy_start_lock", LOCK, 1'b1);
        @(negedge SCLK);
        START = 1'b1;
        @(posedge SCLK);
        #1;
        START = 1'b0;
        check("locked_start_lock", LOCK, 1'b0);
        check("locked_start_busy", BUSY, 1'b1);
        check("locked_start_sel", ALIGN_SEL, 3'd0);
        wait_idle(200, to);
        check("locked_start_relock", {to, LOCK, ALIGN_SEL}, {1'b0, 1'b1, 3'd6});

        // Tracking: 3 bad words hold lock, 4 bad words force re-train
        @(negedge SCLK);
        good_pol = 1'b0;
        sh       = 0;
        run_train(cyc, to);
        check("track_lock", {to, LOCK, ALIGN_SEL}, {1'b0, 1'b1, 3'd0});
        TRACK_EN = 1'b1;
        @(negedge SCLK);
        inject = 1'b1;
        repeat (3) @(negedge SCLK);
        inject = 1'b0;
        drops = 0;
        repeat (12) begin
            @(posedge SCLK);
            #1;
            if (!LOCK) drops++;
        end
        check("track_3bad_hold", drops, 0);
        @(negedge SCLK);
        inject = 1'b1;
        repeat (4) @(negedge SCLK);
        inject = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge SCLK);
            #1;
            if (!LOCK) begin
                found = 1'b1;
                break;
            end
        end
        check("track_4bad_drop", found, 1'b1);
        check("track_drop_busy", BUSY, 1'b1);
        check("track_drop_sel", ALIGN_SEL, 3'd0);
        wait_idle(100, to);
        check("track_relock", {to, LOCK, ALIGN_SEL}, {1'b0, 1'b1, 3'd0});
        TRACK_EN = 1'b0;
        @(negedge SCLK);
        inject = 1'b1;
        repeat (6) @(negedge SCLK);
        inject = 1'b0;
        drops = 0;
        repeat (12) begin
            @(posedge SCLK);
            #1;
            if (!LOCK) drops++;
        end
        check("notrack_hold", drops, 0);

        // Asynchronous reset in CHECK at candidate 5
        @(negedge SCLK);
        good_pol = 1'b1;
        sh       = 3;
        START    = 1'b1;
        found    = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge SCLK);
            #1;
            START = 1'b0;
            if (ALIGN_SEL == 3'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_sel5", found, 1'b1);
        repeat (13) @(posedge SCLK);
        #1;
        check("rst_pre_busy", {BUSY, LOCK, ALIGN_SEL}, {1'b1, 1'b0, 3'd5});
        #3;
        RSTN = 1'b0;
        #1;
        check("rst_async_outputs", {POL, ALIGN_SEL, DOUT, DVALID, BUSY, LOCK, FAIL}, 32'h0);
        repeat (2) @(negedge SCLK);
        RSTN = 1'b1;
        repeat (3) @(posedge SCLK);
        #1;
        check("rst_idle_after", {BUSY, LOCK, FAIL, ALIGN_SEL}, 32'h0);
        run_train(cyc, to);
        check("rst_retrain_cycles", cyc, 70);
        check("rst_retrain_lock", {to, LOCK, ALIGN_SEL}, {1'b0, 1'b1, 3'd5});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
